// File: rtl/ram_port_rr_arbiter_if.sv
// Request/grant bundle between the RAM port arbiter, its requesters and the RAM.
interface ram_port_rr_arbiter_if #(
    parameter int unsigned NB_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic [NB_PORTS-1:0]            port_req_i;
    logic [NB_PORTS*ADDR_WIDTH-1:0] port_addr_i;
    logic [NB_PORTS-1:0]            port_we_i;
    logic [NB_PORTS*BE_WIDTH-1:0]   port_be_i;
    logic [NB_PORTS*DATA_WIDTH-1:0] port_wdata_i;
    logic [NB_PORTS-1:0]            port_gnt_o;
    logic [NB_PORTS-1:0]            port_rvalid_o;
    logic [DATA_WIDTH-1:0]          port_rdata_o;

    // RAM side
    logic                           mem_req_o;
    logic                           mem_gnt_i;
    logic [ADDR_WIDTH-1:0]          mem_addr_o;
    logic                           mem_we_o;
    logic [BE_WIDTH-1:0]            mem_be_o;
    logic [DATA_WIDTH-1:0]          mem_wdata_o;
    logic [DATA_WIDTH-1:0]          mem_rdata_i;

    // Arbiter view
    modport slave (
        input  port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
        output port_gnt_o, port_rvalid_o, port_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rdata_i
    );

    // Environment view: requesters plus RAM
    modport master (
        output port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
        input  port_gnt_o, port_rvalid_o, port_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rdata_i
    );
endinterface

// File: rtl/ram_port_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported RAM between
// NB_PORTS request/grant requesters. Grant is combinational; the response is
// routed back to the granted port exactly one cycle later.
module ram_port_rr_arbiter #(
    parameter int unsigned NB_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_rr_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
    } payload_t;

    payload_t          payload [NB_PORTS];
    payload_t          win_payload;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [PTR_W-1:0]  rsp_owner_q, rsp_owner_d;

    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  cand_idx;
    int unsigned       cand;
    logic              found;
    logic              any_req;
    logic              accept;

    // Slice the flat per-port buses into one payload per port
    for (genvar k = 0; k < NB_PORTS; k++) begin : g_unpack
        assign payload[k] = '{
            addr:  bus.port_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
            we:    bus.port_we_i[k],
            be:    bus.port_be_i[k*BE_W +: BE_W],
            wdata: bus.port_wdata_i[k*DATA_WIDTH +: DATA_WIDTH]
        };
    end

    assign any_req = |bus.port_req_i;
    assign accept  = any_req & bus.mem_gnt_i;

    // First requesting port at or after rr_ptr, wrapping past the top index
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NB_PORTS; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NB_PORTS;
            cand_idx = PTR_W'(cand);
            if (!found && bus.port_req_i[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    // Forward the winner's fields; port 0 when idle (don't-care, req low)
    assign win_payload     = payload[winner];
    assign bus.mem_req_o   = any_req;
    assign bus.mem_addr_o  = win_payload.addr;
    assign bus.mem_we_o    = win_payload.we;
    assign bus.mem_be_o    = win_payload.be;
    assign bus.mem_wdata_o = win_payload.wdata;

    // Grant only the winner, and only while the RAM accepts
    assign bus.port_gnt_o = accept ? (NB_PORTS'(1) << winner) : '0;

    // Response goes to the port accepted in the previous cycle
    assign bus.port_rvalid_o = rsp_valid_q ? (NB_PORTS'(1) << rsp_owner_q) : '0;
    assign bus.port_rdata_o  = bus.mem_rdata_i;

    // Next pointer / pending-response state
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_owner_d = rsp_owner_q;
        if (accept) begin
            rr_ptr_d    = (winner == PTR_W'(NB_PORTS - 1)) ? '0 : winner + PTR_W'(1);
            rsp_valid_d = 1'b1;
            rsp_owner_d = winner;
        end
    end

    // State registers; reset drops any pending response immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end
endmodule

// File: doc/ram_port_rr_arbiter.md
# ram_port_rr_arbiter

Round-robin arbiter that shares one single-ported, fixed-latency data RAM between several PULP-style request/grant requesters. In the core region, these requesters are the core data port, the debug unit and the AXI data slave adapter. The block grants one requester per cycle and forwards its request to the RAM. It then routes the RAM response back to the granted requester exactly one cycle later. It replaces priority-muxed RAM sharing with a fair, starvation-free scheme that the RAM can back-pressure.

## Interface
Parameters:
- NB_PORTS, 3, number of requesters (2..8); port 0 is the lowest index in the round-robin search
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- port_req_i  in  NB_PORTS  per-port request
- port_addr_i  in  NB_PORTS*ADDR_WIDTH  per-port address; port k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- port_we_i  in  NB_PORTS  per-port write enable
- port_be_i  in  NB_PORTS*DATA_WIDTH/8  per-port byte enables
- port_wdata_i  in  NB_PORTS*DATA_WIDTH  per-port write data
- port_gnt_o  out  NB_PORTS  per-port grant, one-hot or zero
- port_rvalid_o  out  NB_PORTS  per-port response valid, one-hot or zero
- port_rdata_o  out  DATA_WIDTH  read data, shared by all ports; qualified by port_rvalid_o
- mem_req_o  out  1  RAM request
- mem_gnt_i  in  1  RAM accepts a request this cycle; 0 means the RAM is stalling
- mem_addr_o  out  ADDR_WIDTH  RAM address
- mem_we_o  out  1  RAM write enable
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after an accepted request

## Operation
- State:
  - rr_ptr: round-robin pointer, $clog2(NB_PORTS) bits
  - rsp_valid_q: response pending, 1 bit
  - rsp_owner_q: index of the port owed the response, $clog2(NB_PORTS) bits
- Winner selection (combinational):
  - Search port_req_i starting at rr_ptr and ascending with wrap-around (NB_PORTS-1 wraps to 0).
  - The winner is the first requesting port found.
- Request forwarding:
  - mem_req_o = |port_req_i.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o carry the winner's fields.
  - When there is no request, these outputs carry port 0's fields. This is don't-care; mem_req_o=0.
- Grant:
  - port_gnt_o[winner] = mem_req_o & mem_gnt_i. All other grant bits are 0.
  - A granted transfer is accepted in the same cycle.
- On an accepted transfer (mem_req_o & mem_gnt_i):
  - rr_ptr <= (winner+1) mod NB_PORTS
  - rsp_valid_q <= 1
  - rsp_owner_q <= winner
- Otherwise: rr_ptr holds and rsp_valid_q <= 0.
- Response:
  - port_rvalid_o[rsp_owner_q] = rsp_valid_q.
  - port_rdata_o = mem_rdata_i, passed through combinationally.
  - Writes also receive rvalid; port_rdata_o is then don't-care.
- Requester protocol:
  - A requester holds req and all its fields stable until it sees gnt.
  - A requester may drop req in the cycle after gnt.
  - The arbiter does not check protocol violations.
- Fairness: with all NB_PORTS requesting continuously, each port is granted exactly once every NB_PORTS accepted cycles.

## Timing
- Reset values:
  - rr_ptr=0, rsp_valid_q=0, rsp_owner_q=0.
  - port_rvalid_o=0 during reset and for the first cycle after reset.
  - port_gnt_o and mem_req_o are 0 whenever port_req_i=0.
- Latency:
  - Request to grant: 0 cycles, combinational, when mem_gnt_i=1.
  - Grant to rvalid: exactly 1 cycle.
- Throughput: one accepted transfer per cycle. Back-to-back grants to the same port are allowed only when no other port requests.
- Back-pressure: while mem_gnt_i=0:
  - No grant is issued.
  - rr_ptr holds, so the same winner is presented when mem_gnt_i returns to 1.
  - mem_req_o stays asserted.
- A new request and the previous response are in flight simultaneously: the rvalid for grant N and the grant N+1 share a cycle with no conflict.
- Combinational paths: port_req_i→port_gnt_o, mem_gnt_i→port_gnt_o and mem_rdata_i→port_rdata_o. There is no path from mem_gnt_i to mem_req_o.
- Reset mid-operation: asserting rst_n low clears a pending response immediately, so no rvalid is issued for a transfer accepted in the cycle before reset.

## Test plan
- Single port: only port 1 requests a read of 0x0000_0040 with mem_rdata_i=0xDEAD_BEEF.
  - Same cycle: port_gnt_o=3'b010 and mem_addr_o=0x40.
  - Next cycle: port_rvalid_o=3'b010 and port_rdata_o=0xDEAD_BEEF.
  - rr_ptr becomes 2.
- Full contention: all 3 ports request continuously for 6 cycles from reset.
  - Grant sequence: 0,1,2,0,1,2.
  - Each rvalid arrives one cycle after its grant and targets the matching port.
- Back-pressure: ports 0 and 2 request and mem_gnt_i=0 for 3 cycles.
  - During the stall: no grants, mem_req_o=1, mem_addr_o holds port 0's address.
  - mem_gnt_i=1: port 0 is granted, then port 2 in the next cycle.
- Write path: port 2 writes wdata=0x1234_5678 with be=4'b0011.
  - mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0x1234_5678.
  - port_rvalid_o=3'b100 one cycle later.
- Pointer wrap with sparse requests: port 2 is granted (rr_ptr becomes 0), then ports 1 and 2 request.
  - Port 1 is granted first, then port 2.
- Reset mid-transfer: rst_n is pulled low in the cycle after port 0 is granted.
  - port_rvalid_o=0 immediately.
  - After release: rr_ptr=0 and port_rvalid_o stays 0 until a new grant.
